// File: rtl/uart_pkg.sv
// Shared constants and types for the 8N1 UART receive path.
package uart_pkg;

    localparam int unsigned CLKS_PER_BIT_DEF = 868;
    localparam int unsigned WIDTH_DEF        = 8;
    localparam int unsigned HALF_BIT_DEF     = CLKS_PER_BIT_DEF / 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    // Mid-bit offset for a given bit period.
    function automatic int unsigned half_bit(input int unsigned clks_per_bit);
        return clks_per_bit / 2;
    endfunction

endpackage

// File: rtl/uart_receiver_if.sv
// Serial input, hold control and parallel result of the UART receiver.
interface uart_receiver_if
    import uart_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
);
    logic             data;
    logic             hold_value;
    logic [WIDTH-1:0] rx;
    logic             rx_valid;
    logic             frame_error;
    logic             busy;

    modport master (
        output data, hold_value,
        input  rx, rx_valid, frame_error, busy
    );

    modport slave (
        input  data, hold_value,
        output rx, rx_valid, frame_error, busy
    );
endinterface

// File: rtl/baud_unit.sv
// Bit-period counter that strobes once per bit at the mid-bit point.
module baud_unit
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic restart,
    output logic sample_c
);
    localparam int unsigned CNT_W     = $clog2(CLKS_PER_BIT);
    localparam int unsigned SAMPLE_AT = half_bit(CLKS_PER_BIT) - 1;
    localparam int unsigned LAST      = CLKS_PER_BIT - 1;

    logic [CNT_W-1:0] cnt;

    // Held at zero while idle so every start bit begins a fresh bit period.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (!enable || restart) begin
            cnt <= '0;
        end else if (cnt == CNT_W'(LAST)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign sample_c = enable && !restart && (cnt == CNT_W'(SAMPLE_AT));

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: start detect, mid-bit sampling, stop check, byte output.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int unsigned WIDTH        = WIDTH_DEF
) (
    input  logic            clk,
    input  logic            reset,
    uart_receiver_if.slave  bus
);
    localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] bit_idx_q, bit_idx_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] rx_q, rx_d;
    logic             rx_valid_q, rx_valid_d;
    logic             frame_error_q, frame_error_d;
    logic             busy_q, busy_d;
    logic             sync1_q, sync2_q, prev_q;
    logic             fall_c, start_c, sample_c;

    // Synchroniser flops reset low so a line already low at release is not an edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= bus.data;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign fall_c = prev_q && !sync2_q;

    baud_unit #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk      (clk),
        .reset    (reset),
        .enable   (state_q != IDLE),
        .restart  (start_c),
        .sample_c (sample_c)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            bit_idx_q     <= '0;
            shift_q       <= '0;
            rx_q          <= '0;
            rx_valid_q    <= 1'b0;
            frame_error_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            bit_idx_q     <= bit_idx_d;
            shift_q       <= shift_d;
            rx_q          <= rx_d;
            rx_valid_q    <= rx_valid_d;
            frame_error_q <= frame_error_d;
            busy_q        <= busy_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        bit_idx_d     = bit_idx_q;
        shift_d       = shift_q;
        rx_d          = rx_q;
        rx_valid_d    = 1'b0;
        frame_error_d = 1'b0;
        start_c       = 1'b0;

        case (state_q)
            IDLE: begin
                if (fall_c) begin
                    state_d   = START;
                    bit_idx_d = '0;
                    start_c   = 1'b1;
                end
            end
            START: begin
                // A line back high at mid start bit was a glitch.
                if (sample_c) begin
                    state_d   = sync2_q ? IDLE : DATA;
                    bit_idx_d = '0;
                end
            end
            DATA: begin
                if (sample_c) begin
                    shift_d[bit_idx_q] = sync2_q;
                    if (bit_idx_q == IDX_W'(WIDTH - 1)) begin
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + IDX_W'(1);
                    end
                end
            end
            STOP: begin
                if (sample_c) begin
                    state_d = IDLE;
                    if (sync2_q) begin
                        if (!bus.hold_value) begin
                            rx_d       = shift_q;
                            rx_valid_d = 1'b1;
                        end
                    end else begin
                        frame_error_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    assign bus.rx          = rx_q;
    assign bus.rx_valid    = rx_valid_q;
    assign bus.frame_error = frame_error_q;
    assign bus.busy        = busy_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboard bench for uart_receiver: directed frames, glitch, hold and reset.
module tb_uart_receiver;
    import uart_pkg::*;

    localparam int unsigned CPB = 217;

    typedef struct packed {
        logic       ferr;
        logic [7:0] value;
    } exp_t;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    exp_t exp_q[$];

    uart_receiver_if #(.WIDTH(8)) bus ();

    uart_receiver #(
        .CLKS_PER_BIT (CPB),
        .WIDTH        (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: every output pulse must match the oldest expected event.
    always @(negedge clk) begin
        if (reset && (bus.rx_valid || bus.frame_error)) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event rx_valid=%0b frame_error=%0b rx=%02h", bus.rx_valid,
                         bus.frame_error, bus.rx);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (bus.frame_error !== e.ferr || bus.rx_valid !== !e.ferr || bus.rx !== e.value) begin
                    errors++;
                    $display("FAIL event got rx_valid=%0b frame_error=%0b rx=%02h want rx_valid=%0b frame_error=%0b rx=%02h",
                             bus.rx_valid, bus.frame_error, bus.rx, !e.ferr, e.ferr, e.value);
                end
            end
        end
    end

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%02h want=%02h", name, got, want);
        end
    endtask

    task automatic wait_cycles(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic v);
        bus.data = v;
        wait_cycles(CPB);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop_bit);
    endtask

    task automatic push(input logic ferr, input logic [7:0] value);
        exp_t e;
        e.ferr  = ferr;
        e.value = value;
        exp_q.push_back(e);
    endtask

    // All expected events for the previous frames must have been consumed.
    task automatic check_drained(input string name);
        check(name, 8'(exp_q.size()), 8'd0);
        exp_q.delete();
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        reset          = 1'b0;
        bus.data       = 1'b1;
        bus.hold_value = 1'b0;

        #100;
        check("reset_rx", bus.rx, 8'h00);
        check("reset_rx_valid", 8'(bus.rx_valid), 8'd0);
        check("reset_frame_error", 8'(bus.frame_error), 8'd0);
        check("reset_busy", 8'(bus.busy), 8'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        wait_cycles(CPB);

        // Single frame, then a long idle with rx holding its value.
        push(1'b0, 8'h99);
        send_frame(8'h99, 1'b1);
        check_drained("single_frame_done");
        wait_cycles(10 * CPB);
        check("single_rx_hold", bus.rx, 8'h99);
        check("single_idle_busy", 8'(bus.busy), 8'd0);

        // Back-to-back frames with no idle gap.
        push(1'b0, 8'h55);
        push(1'b0, 8'hA3);
        send_frame(8'h55, 1'b1);
        send_frame(8'hA3, 1'b1);
        check_drained("b2b_done");
        check("b2b_rx", bus.rx, 8'hA3);

        // Low stop bit: frame_error only, rx unchanged.
        push(1'b1, 8'hA3);
        send_frame(8'h0F, 1'b0);
        bus.data = 1'b1;
        wait_cycles(CPB);
        check_drained("frame_error_done");
        check("frame_error_rx", bus.rx, 8'hA3);

        // Short start glitch is rejected, then a normal frame is received.
        bus.data = 1'b0;
        wait_cycles(CPB / 4);
        check("glitch_busy_high", 8'(bus.busy), 8'd1);
        bus.data = 1'b1;
        wait_cycles(CPB);
        check("glitch_busy_low", 8'(bus.busy), 8'd0);
        check("glitch_rx", bus.rx, 8'hA3);
        push(1'b0, 8'h5A);
        send_frame(8'h5A, 1'b1);
        check_drained("glitch_next_done");

        // Hold: second frame is discarded and rx stays frozen.
        push(1'b0, 8'h99);
        send_frame(8'h99, 1'b1);
        bus.hold_value = 1'b1;
        send_frame(8'h3C, 1'b1);
        check_drained("hold_done");
        check("hold_rx", bus.rx, 8'h99);
        bus.hold_value = 1'b0;
        wait_cycles(CPB);

        // Mid-frame reset clears rx at once; a line held low is not a start.
        bus.data = 1'b0;
        wait_cycles(3 * CPB);
        check("midframe_busy", 8'(bus.busy), 8'd1);
        reset = 1'b0;
        #1;
        check("reset_mid_rx", bus.rx, 8'h00);
        check("reset_mid_busy", 8'(bus.busy), 8'd0);
        wait_cycles(5);
        reset = 1'b1;
        wait_cycles(2 * CPB);
        check("low_after_reset_busy", 8'(bus.busy), 8'd0);
        bus.data = 1'b1;
        wait_cycles(CPB);
        push(1'b0, 8'h81);
        send_frame(8'h81, 1'b1);
        check_drained("after_reset_done");
        check("after_reset_rx", bus.rx, 8'h81);

        // Break: a continuously low line yields a single frame_error.
        push(1'b1, 8'h81);
        bus.data = 1'b0;
        wait_cycles(20 * CPB);
        check_drained("break_done");
        check("break_busy", 8'(bus.busy), 8'd0);
        bus.data = 1'b1;
        wait_cycles(CPB);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
